seg7_scan_capture: RTL and testbench
====================================

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 Parameter STABLE_CNT, default 4: consecutive identical clock samples required before a digit is captured; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 an_n  input  4  digit enables of a multiplexed display, active-low; bit i low selects digit i.
REQ-005 seg_n  input  7  segment lines {g,f,e,d,c,b,a} from bit 6 down to bit 0, active-low (0 = segment lit).
REQ-006 bcd  output  16  captured digit values; digit i occupies bits [4i+3:4i].
REQ-007 digit_err  output  4  per-digit flag; 1 = last capture for that digit was an unrecognised pattern.
REQ-008 frame_valid  output  1  one-cycle pulse when all four digits have been captured since the last pulse.

Function
REQ-009 Inputs are registered once, into s_an and s_seg, every cycle; all decisions use these registered copies.
REQ-010 Pattern table, seg_n in hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-011 Hex patterns: A=08, b=03, C=46, d=21, E=06, F=0E (availability per REQ-025).
REQ-012 an_n is valid only when exactly one bit is low; any other value (none low or several low) is invalid.
REQ-013 State machine states:
- WAIT: no valid digit selected.
- SETTLE: counting stable samples.
- HOLD: digit captured; waiting for the inputs to change.
REQ-014 Transitions from WAIT and SETTLE:
- WAIT -> SETTLE on a valid s_an; the counter loads 1.
- SETTLE, inputs equal to the previous sample: the counter increments.
- SETTLE, inputs differ: stay in SETTLE with the counter reloaded to 1.
- SETTLE, s_an invalid: go to WAIT.
REQ-015 SETTLE -> HOLD on the cycle the counter reaches STABLE_CNT; the capture occurs on that edge.
REQ-016 Capture of digit i:
- bcd[4i+3:4i] gets the decoded value and digit_err[i] is cleared, for a recognised pattern.
- For an unrecognised pattern, the bcd field keeps its previous value and digit_err[i] is set.
REQ-017 Transitions from HOLD:
- Any change of s_an or s_seg while valid goes to SETTLE with the counter at 1.
- Invalid s_an goes to WAIT.
- HOLD never re-captures the same unchanged digit.
REQ-018 Latency: a digit stable from cycle N on the pins updates bcd at the edge ending cycle N+STABLE_CNT.
REQ-019 A captured bitmap records which digits were captured, including error captures.
REQ-020 When a capture makes the bitmap 4'b1111:
- frame_valid pulses for exactly that cycle.
- The bitmap clears to 0000 on the same edge.
- Repeated captures of an already-set digit do not pulse.
REQ-021 A blank pattern (7F) is unrecognised and sets digit_err.

Reset
REQ-022 When reset is high on a clock edge:
- The state goes to WAIT and the counter, the captured bitmap, s_an and s_seg clear.
- bcd clears to 0, digit_err to 0 and frame_valid to 0.
REQ-023 Reset asserted mid-SETTLE discards the partial count; no capture occurs on that edge.
REQ-024 After reset deasserts, the first capture requires a full STABLE_CNT stable samples.

Configuration
REQ-025 Macro SEG7_HEX_DIGITS_EN:
- Defined: the REQ-011 patterns decode to values 10..15 with digit_err cleared.
- Undefined: those patterns are unrecognised per REQ-016.

Verification
REQ-026 Reset, then an_n=E, seg_n=24 held for 6 cycles -> bcd[3:0]=2 exactly 4 edges after the first sampled cycle, digit_err[0]=0.
REQ-027 Scan of an_n E,D,B,7 carrying 1,2,3,4, 5 cycles each -> bcd=16'h4321 and a single frame_valid pulse on the digit-3 capture.
REQ-028 an_n=E with seg_n alternating 30/19 every 2 cycles for 20 cycles -> no capture; bcd unchanged.
REQ-029 an_n=C (two digits selected) held for 10 cycles -> the state stays in WAIT and bcd is unchanged.
REQ-030 an_n=B, seg_n=46 held 5 cycles -> with the macro, bcd[11:8]=C and err=0; without it, digit_err[2]=1 and bcd[11:8] is unchanged.
REQ-031 Reset pulsed on the 3rd cycle of a stable digit -> all outputs are 0; a capture occurs only 4 cycles after reset deasserts.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// Recovers the digit values shown on a multiplexed, active-low 7-segment display.
// Optional build macro SEG7_HEX_DIGITS_EN additionally decodes the hex letters A..F.
module seg7_scan_capture #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an_n,
  input  logic [6:0]  seg_n,
  output logic [15:0] bcd,
  output logic [3:0]  digit_err,
  output logic        frame_valid
);

  localparam logic [7:0] STABLE_CNT8 = 8'(STABLE_CNT);

  typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [3:0]  s_an, an_p1;
  logic [6:0]  s_seg, seg_p1;
  logic [3:0]  captured;

  logic        an_ok;
  logic        same;
  logic [1:0]  idx;
  logic        capture;
  logic        dec_ok;
  logic [3:0]  dec_val;
  logic [3:0]  bmp_next;
  logic        frame_hit;

  function automatic logic an_valid(input logic [3:0] an);
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: an_valid = 1'b1;
      default:                            an_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    case (an)
      4'b1101: an_index = 2'd1;
      4'b1011: an_index = 2'd2;
      4'b0111: an_index = 2'd3;
      default: an_index = 2'd0;
    endcase
  endfunction

  // Returns {recognised, value}; unlisted patterns (including blank) are rejected.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_decode = {1'b1, 4'd0};
      7'h79:   seg_decode = {1'b1, 4'd1};
      7'h24:   seg_decode = {1'b1, 4'd2};
      7'h30:   seg_decode = {1'b1, 4'd3};
      7'h19:   seg_decode = {1'b1, 4'd4};
      7'h12:   seg_decode = {1'b1, 4'd5};
      7'h02:   seg_decode = {1'b1, 4'd6};
      7'h78:   seg_decode = {1'b1, 4'd7};
      7'h00:   seg_decode = {1'b1, 4'd8};
      7'h10:   seg_decode = {1'b1, 4'd9};
`ifdef SEG7_HEX_DIGITS_EN
      7'h08:   seg_decode = {1'b1, 4'd10};
      7'h03:   seg_decode = {1'b1, 4'd11};
      7'h46:   seg_decode = {1'b1, 4'd12};
      7'h21:   seg_decode = {1'b1, 4'd13};
      7'h06:   seg_decode = {1'b1, 4'd14};
      7'h0E:   seg_decode = {1'b1, 4'd15};
`else
`endif
      default: seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  // Input sampling stage: s_* hold this cycle's pins, *_p1 the previous sample
  always_ff @(posedge clk) begin
    if (reset) begin
      s_an   <= 4'd0;
      s_seg  <= 7'd0;
      an_p1  <= 4'd0;
      seg_p1 <= 7'd0;
    end else begin
      s_an   <= an_n;
      s_seg  <= seg_n;
      an_p1  <= s_an;
      seg_p1 <= s_seg;
    end
  end

  assign an_ok = an_valid(s_an);
  assign same  = (s_an == an_p1) && (s_seg == seg_p1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT: begin
        if (an_ok) begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'd1;
        end
      end
      SETTLE: begin
        if (!an_ok) begin
          state_nxt = WAIT;
          cnt_nxt   = 8'd0;
        end else if (!same) begin
          cnt_nxt   = 8'd1;
        end else begin
          cnt_nxt   = cnt + 8'd1;
          if (cnt + 8'd1 == STABLE_CNT8) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!an_ok) begin
          state_nxt = WAIT;
          cnt_nxt   = 8'd0;
        end else if (!same) begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'd1;
        end
      end
      default: begin
        state_nxt = WAIT;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_comb begin
    capture   = (state == SETTLE) && an_ok && same && (cnt + 8'd1 == STABLE_CNT8);
    idx       = an_index(s_an);
    {dec_ok, dec_val} = seg_decode(s_seg);
    bmp_next  = captured | (4'b0001 << idx);
    frame_hit = capture && (bmp_next == 4'b1111);
  end

  // Capture stage: results visible the cycle after the deciding edge
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd         <= 16'd0;
      digit_err   <= 4'd0;
      captured    <= 4'd0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_hit;
      if (capture) begin
        captured       <= frame_hit ? 4'b0000 : bmp_next;
        digit_err[idx] <= ~dec_ok;
        if (dec_ok) bcd[{idx, 2'b00} +: 4] <= dec_val;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed-vector bench for seg7_scan_capture; expected outputs are queued by the
// stimulus with their due cycle and checked every cycle by an independent monitor.
module tb_seg7_scan_capture;

  localparam int STABLE_CNT = 4;
  localparam int CAP_LAT    = STABLE_CNT + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [15:0] bcd;
  logic [3:0]  digit_err;
  logic        frame_valid;

  seg7_scan_capture #(.STABLE_CNT(STABLE_CNT)) dut (
    .clk(clk), .reset(reset), .an_n(an_n), .seg_n(seg_n),
    .bcd(bcd), .digit_err(digit_err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        fv;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  bit          done = 1'b0;
  logic [15:0] cur_bcd = 16'd0;
  logic [3:0]  cur_err = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs must hold the last expected state except on a due cycle
  always @(negedge clk) begin
    logic exp_fv;
    exp_t r;
    if (cyc >= 1 && !done) begin
      exp_fv = 1'b0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        r       = sb.pop_front();
        cur_bcd = r.bcd;
        cur_err = r.err;
        exp_fv  = r.fv;
      end
      checks++;
      if ({bcd, digit_err, frame_valid} !== {cur_bcd, cur_err, exp_fv}) begin
        fails++;
        $display("FAIL outputs@cyc%0d: got bcd=%h err=%b fv=%b, want bcd=%h err=%b fv=%b",
                 cyc, bcd, digit_err, frame_valid, cur_bcd, cur_err, exp_fv);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int hold,
                       input bit cap, input logic [15:0] b, input logic [3:0] e,
                       input logic f);
    exp_t r;
    an_n  = an;
    seg_n = seg;
    if (cap) begin
      r = '{cyc + CAP_LAT, b, e, f};
      sb.push_back(r);
    end
    repeat (hold) step();
  endtask

  initial begin
    exp_t r;
    reset = 1'b1;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single digit '2' on digit 0
    drive(4'hE, 7'h24, 6, 1, 16'h0002, 4'b0000, 1'b0);

    // Full scan 1,2,3,4; digit 0 recapture must not complete a frame early
    drive(4'hE, 7'h79, 5, 1, 16'h0001, 4'b0000, 1'b0);
    drive(4'hD, 7'h24, 5, 1, 16'h0021, 4'b0000, 1'b0);
    drive(4'hB, 7'h30, 5, 1, 16'h0321, 4'b0000, 1'b0);
    drive(4'h7, 7'h19, 5, 1, 16'h4321, 4'b0000, 1'b1);

    // Flicker never settles long enough
    for (int i = 0; i < 5; i++) begin
      drive(4'hE, 7'h30, 2, 0, 16'h0, 4'h0, 1'b0);
      drive(4'hE, 7'h19, 2, 0, 16'h0, 4'h0, 1'b0);
    end

    // Two digits selected at once
    drive(4'hC, 7'h30, 10, 0, 16'h0, 4'h0, 1'b0);

`ifdef SEG7_HEX_DIGITS_EN
    drive(4'hB, 7'h46, 5, 1, 16'h4C21, 4'b0000, 1'b0);
    drive(4'h7, 7'h7F, 5, 1, 16'h4C21, 4'b1000, 1'b0);
    drive(4'hE, 7'h00, 5, 1, 16'h4C28, 4'b1000, 1'b0);
    drive(4'hD, 7'h10, 8, 1, 16'h4C98, 4'b1000, 1'b1);
`else
    drive(4'hB, 7'h46, 5, 1, 16'h4321, 4'b0100, 1'b0);
    drive(4'h7, 7'h7F, 5, 1, 16'h4321, 4'b1100, 1'b0);
    drive(4'hE, 7'h00, 5, 1, 16'h4328, 4'b1100, 1'b0);
    drive(4'hD, 7'h10, 8, 1, 16'h4398, 4'b1100, 1'b1);
`endif

    // Reset during the third stable cycle, then a full fresh settle
    drive(4'hE, 7'h02, 2, 0, 16'h0, 4'h0, 1'b0);
    reset = 1'b1;
    r = '{cyc + 1, 16'h0000, 4'b0000, 1'b0};
    sb.push_back(r);
    step();
    reset = 1'b0;
    r = '{cyc + CAP_LAT, 16'h0006, 4'b0000, 1'b0};
    sb.push_back(r);
    repeat (8) step();

    drive(4'hF, 7'h7F, 4, 0, 16'h0, 4'h0, 1'b0);
    done = 1'b1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
